// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment driver: scans DIGITS hex digits with per-digit dp/blank,
// leading-zero suppression, PWM brightness, guard time and frame-synchronous updates.

module seg_scan_digit #(
  parameter bit IS_LSD = 1'b0
) (
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  input  logic       i_blank,
  input  logic       i_lz_en,
  input  logic       i_hi_zero,   // this nibble and every more significant one are zero
  output logic [7:0] o_seg,       // {dp,g,f,e,d,c,b,a}, active high
  output logic       o_dark
);
  logic [6:0] w_glyph;

  always_comb begin
    w_glyph = 7'h00;
    case (i_nib)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h39;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      4'hF: w_glyph = 7'h71;
    endcase
  end

  assign o_seg  = {i_dp, w_glyph};
  // The rightmost digit always shows something, even for an all-zero value.
  assign o_dark = i_blank | (i_lz_en & ~IS_LSD & i_hi_zero);
endmodule

module seg_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 10000,
  parameter int PWM_BITS    = 4,
  parameter int GUARD       = 2,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_en,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_suppress,
  input  logic [PWM_BITS-1:0]   brightness,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_done
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int OW = PW + PWM_BITS + 1;

  localparam logic [7:0]        SEG_OFF = {8{SEG_ACT_LOW}};
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACT_LOW}};

  logic [PW-1:0]          r_presc;
  logic [IW-1:0]          r_idx;
  logic                   r_frame_done;

  logic [4*DIGITS-1:0]    r_stg_data, r_act_data;
  logic [DIGITS-1:0]      r_stg_dp,   r_act_dp;
  logic [DIGITS-1:0]      r_stg_blank, r_act_blank;
  logic                   r_stg_lz,   r_act_lz;
  logic                   r_pending;

  logic [7:0]             r_seg;
  logic [DIGITS-1:0]      r_dig;

  logic                   w_slot_end, w_frame_end;
  logic [OW-1:0]          w_br_plus1, w_prod, w_on_ticks, w_lit_end, w_presc_ext;
  logic                   w_lit, w_on;
  logic [DIGITS-1:0]      w_hi_zero;
  logic [DIGITS-1:0][7:0] w_seg_raw;
  logic [DIGITS-1:0]      w_dark;
  logic [7:0]             w_sel_seg;
  logic                   w_sel_dark;
  logic [DIGITS-1:0]      w_dig_oh;
  logic [7:0]             w_seg_nxt;
  logic [DIGITS-1:0]      w_dig_nxt;

  assign w_slot_end  = (r_presc == PW'(SCAN_DIV - 1));
  assign w_frame_end = w_slot_end & (r_idx == IW'(DIGITS - 1));

  // Scan timebase: prescaler inside a slot, idx selects the digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_slot_end ? '0 : r_presc + 1'b1;
      r_frame_done <= w_frame_end;
      if (w_slot_end)
        r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  // Loads land in staging; active only changes at a frame boundary so a frame never tears.
  // A load on the boundary cycle itself stays pending for the following boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stg_data  <= '0;
      r_stg_dp    <= '0;
      r_stg_blank <= '0;
      r_stg_lz    <= 1'b0;
      r_act_data  <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '0;
      r_act_lz    <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      if (load) begin
        r_stg_data  <= data;
        r_stg_dp    <= dp_en;
        r_stg_blank <= blank;
        r_stg_lz    <= lz_suppress;
      end
      if (w_frame_end && r_pending) begin
        r_act_data  <= r_stg_data;
        r_act_dp    <= r_stg_dp;
        r_act_blank <= r_stg_blank;
        r_act_lz    <= r_stg_lz;
      end
      if (load)
        r_pending <= 1'b1;
      else if (w_frame_end)
        r_pending <= 1'b0;
    end
  end

  // PWM window: product is wide enough that nothing is lost before the shift.
  assign w_br_plus1  = OW'(brightness) + OW'(1);
  assign w_prod      = w_br_plus1 * OW'(SCAN_DIV);
  assign w_on_ticks  = w_prod >> PWM_BITS;
  assign w_lit_end   = (w_on_ticks > OW'(GUARD)) ? w_on_ticks : OW'(GUARD + 1);
  assign w_presc_ext = OW'(r_presc);
  assign w_lit       = (w_presc_ext >= OW'(GUARD)) && (w_presc_ext < w_lit_end);

  always_comb begin
    logic w_run;
    w_run     = 1'b1;
    w_hi_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_run        = w_run & (r_act_data[4*i +: 4] == 4'h0);
      w_hi_zero[i] = w_run;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg_scan_digit #(.IS_LSD(g == 0)) u_dig (
      .i_nib     (r_act_data[4*g +: 4]),
      .i_dp      (r_act_dp[g]),
      .i_blank   (r_act_blank[g]),
      .i_lz_en   (r_act_lz),
      .i_hi_zero (w_hi_zero[g]),
      .o_seg     (w_seg_raw[g]),
      .o_dark    (w_dark[g])
    );
  end

  assign w_sel_seg  = w_seg_raw[r_idx];
  assign w_sel_dark = w_dark[r_idx];
  assign w_dig_oh   = DIGITS'(1) << r_idx;
  assign w_on       = w_lit & ~w_sel_dark;
  assign w_seg_nxt  = (w_on ? w_sel_seg : 8'h00) ^ SEG_OFF;
  assign w_dig_nxt  = (w_on ? w_dig_oh : '0) ^ DIG_OFF;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg <= SEG_OFF;
      r_dig <= DIG_OFF;
    end else begin
      r_seg <= w_seg_nxt;
      r_dig <= w_dig_nxt;
    end
  end

  assign seg        = r_seg;
  assign dig        = r_dig;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: two configurations driven from shared inputs, checked every
// cycle against a timeline model plus hand-computed literal points.

module tb_seg_scan_mux;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_en = '0, blank = '0, brightness = 4'hF;
  logic        lz_suppress = 1'b0, load = 1'b0;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  dig_a, dig_b;
  logic        fd_a, fd_b;

  int n_chk = 0, n_err = 0;
  int t = 0;

  typedef struct {int tl; logic [15:0] d; logic [3:0] dp; logic [3:0] bl; logic lz;} ld_t;
  ld_t loads[$];

  localparam logic [7:0] HEX [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  always #5 clk = ~clk;

  seg_scan_mux #(.DIGITS(4), .SCAN_DIV(8), .PWM_BITS(4), .GUARD(2),
                 .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .data(data), .dp_en(dp_en), .blank(blank),
    .lz_suppress(lz_suppress), .brightness(brightness), .load(load),
    .seg(seg_a), .dig(dig_a), .frame_done(fd_a));

  seg_scan_mux #(.DIGITS(4), .SCAN_DIV(16), .PWM_BITS(4), .GUARD(2),
                 .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .data(data), .dp_en(dp_en), .blank(blank),
    .lz_suppress(lz_suppress), .brightness(brightness), .load(load),
    .seg(seg_b), .dig(dig_b), .frame_done(fd_b));

  task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0d)", nm, a, e, t);
    end
  endtask

  // Output after the edge that consumed cycle tc, for a 4-digit, GUARD=2, 4-bit PWM unit.
  // Active contents = last load taken strictly before the most recent frame-boundary cycle.
  function automatic void model(input int sd, input bit sl, input bit dl, input int tc,
                                input logic [3:0] br, output logic [7:0] es,
                                output logic [3:0] ed, output logic ef);
    int f, k, b, p, ix, on, lim;
    logic [15:0] d; logic [3:0] dp, bl; logic lz; bit lit, dark;
    f = sd * 4; k = tc / f; p = tc % sd; ix = (tc / sd) % 4;
    d = '0; dp = '0; bl = '0; lz = 1'b0;
    if (k > 0) begin
      b = k * f - 1;
      foreach (loads[i])
        if (loads[i].tl < b) begin
          d = loads[i].d; dp = loads[i].dp; bl = loads[i].bl; lz = loads[i].lz;
        end
    end
    on   = ((int'(br) + 1) * sd) >> 4;
    lim  = (on > 3) ? on : 3;
    lit  = (p >= 2) && (p < lim);
    dark = bl[ix] || (lz && ix > 0 && ((d >> (ix * 4)) == 16'h0));
    es = 8'h00; ed = 4'h0;
    if (lit && !dark) begin
      es = HEX[d[ix*4 +: 4]] | {dp[ix], 7'b0};
      ed = 4'b0001 << ix;
    end
    if (sl) es = ~es;
    if (dl) ed = ~ed;
    ef = (p == sd - 1) && (ix == 3);
  endfunction

  always @(posedge clk) begin
    logic [7:0] esa, esb; logic [3:0] eda, edb; logic efa, efb;
    if (!reset_n) begin
      t = 0;
      loads.delete();
      #1;
      chk("rst_seg_a", seg_a, 8'h00);
      chk("rst_dig_a", {4'h0, dig_a}, 8'h0F);
      chk("rst_fd_a", {7'h0, fd_a}, 8'h00);
      chk("rst_seg_b", seg_b, 8'hFF);
      chk("rst_dig_b", {4'h0, dig_b}, 8'h00);
      chk("rst_fd_b", {7'h0, fd_b}, 8'h00);
    end else begin
      model(8, 1'b0, 1'b1, t, brightness, esa, eda, efa);
      model(16, 1'b1, 1'b0, t, brightness, esb, edb, efb);
      if (load) loads.push_back('{t, data, dp_en, blank, lz_suppress});
      t++;
      #1;
      chk("seg_a", seg_a, esa);
      chk("dig_a", {4'h0, dig_a}, {4'h0, eda});
      chk("fd_a", {7'h0, fd_a}, {7'h0, efa});
      chk("seg_b", seg_b, esb);
      chk("dig_b", {4'h0, dig_b}, {4'h0, edb});
      chk("fd_b", {7'h0, fd_b}, {7'h0, efb});
    end
  end

  // Return once the output that reflects cycle n is visible.
  task automatic wait_out(input int n);
    int g = 0;
    while (t < n + 1 && g < 2000) begin
      @(posedge clk); #2; g++;
    end
    if (g >= 2000) begin
      n_chk++; n_err++;
      $display("FAIL wait_out: timeout waiting for cycle %0d, t=%0d", n, t);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                         input logic lz);
    @(negedge clk);
    data = d; dp_en = dp; blank = bl; lz_suppress = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int base, bnd, g;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic scan of 0x12AF on the SCAN_DIV=8 unit
    do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
    wait_out(31); chk("lit_fd_a", {7'h0, fd_a}, 8'h01);
    wait_out(33); chk("lit_guard_dig", {4'h0, dig_a}, 8'h0F);
                  chk("lit_guard_seg", seg_a, 8'h00);
    wait_out(35); chk("lit_d0_seg", seg_a, 8'h71); chk("lit_d0_dig", {4'h0, dig_a}, 8'h0E);
    wait_out(43); chk("lit_d1_seg", seg_a, 8'h77); chk("lit_d1_dig", {4'h0, dig_a}, 8'h0D);
    wait_out(51); chk("lit_d2_seg", seg_a, 8'h5B); chk("lit_d2_dig", {4'h0, dig_a}, 8'h0B);
    wait_out(59); chk("lit_d3_seg", seg_a, 8'h06); chk("lit_d3_dig", {4'h0, dig_a}, 8'h07);
    wait_out(63); chk("lit_fd_a2", {7'h0, fd_a}, 8'h01);

    // Leading-zero suppression
    do_load(16'h0050, 4'h0, 4'h0, 1'b1);
    base = ((t / 32) + 2) * 32;
    wait_out(base + 3);  chk("lz_d0", seg_a, 8'h3F);
    wait_out(base + 11); chk("lz_d1", seg_a, 8'h6D);
    wait_out(base + 19); chk("lz_d2_dark", {4'h0, dig_a}, 8'h0F);
    wait_out(base + 27); chk("lz_d3_dark", {4'h0, dig_a}, 8'h0F);
    do_load(16'h0000, 4'h0, 4'h0, 1'b1);
    base = ((t / 32) + 2) * 32;
    wait_out(base + 3);  chk("lz0_d0", seg_a, 8'h3F);
    wait_out(base + 11); chk("lz0_d1_dark", {4'h0, dig_a}, 8'h0F);

    // Tear-free update, then a load right on the boundary cycle
    do_load(16'h1111, 4'h0, 4'h0, 1'b0);
    base = ((t / 32) + 2) * 32;
    wait_out(base + 3);
    do_load(16'h2222, 4'h0, 4'h0, 1'b0);
    wait_out(base + 27); chk("tear_old", seg_a, 8'h06);
    wait_out(base + 35); chk("tear_new", seg_a, 8'h5B);
    g = 0;
    @(negedge clk);
    while (t % 32 != 31 && g < 100) begin @(negedge clk); g++; end
    bnd = t;
    data = 16'h3333; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_out(bnd + 4);  chk("bnd_defer", seg_a, 8'h5B);
    wait_out(bnd + 36); chk("bnd_next", seg_a, 8'h4F);

    // Blank / dp on both polarities
    do_load(16'h8888, 4'b0001, 4'b0100, 1'b0);
    base = ((t / 64) + 2) * 64;
    wait_out(base + 3);
    chk("dp_a_d0", seg_a, 8'hFF); chk("dp_b_d0", seg_b, 8'h00);
    chk("dp_b_dig", {4'h0, dig_b}, 8'h01);
    wait_out(base + 11); chk("dp_a_d1", seg_a, 8'h7F);
    wait_out(base + 19);
    chk("blank_a_d2", {4'h0, dig_a}, 8'h0F); chk("dp_b_d1", seg_b, 8'h80);
    wait_out(base + 35);
    chk("blank_b_d2", {4'h0, dig_b}, 8'h00); chk("blank_b_seg", seg_b, 8'hFF);

    // Brightness windows on the SCAN_DIV=16 unit
    @(negedge clk); brightness = 4'h0;
    base = ((t / 64) + 1) * 64;
    wait_out(base + 2); chk("br0_on", {4'h0, dig_b}, 8'h01);
    wait_out(base + 3); chk("br0_off", {4'h0, dig_b}, 8'h00);
    @(negedge clk); brightness = 4'h7;
    base = ((t / 64) + 1) * 64;
    wait_out(base + 7); chk("br7_on", {4'h0, dig_b}, 8'h01);
    wait_out(base + 8); chk("br7_off", {4'h0, dig_b}, 8'h00);
    @(negedge clk); brightness = 4'hF;
    base = ((t / 64) + 1) * 64;
    wait_out(base + 15); chk("brF_on", {4'h0, dig_b}, 8'h01);

    // Randomized traffic, biased toward zero nibbles for suppression coverage
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      load = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        for (int n = 0; n < 4; n++)
          data[n*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        dp_en = 4'($urandom); blank = 4'($urandom & $urandom);
        lz_suppress = 1'($urandom); load = 1'b1;
      end
      if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
    end
    @(negedge clk); load = 1'b0;

    // Asynchronous reset in the middle of a slot
    #3 reset_n = 1'b0;
    #1;
    chk("async_seg_a", seg_a, 8'h00); chk("async_dig_a", {4'h0, dig_a}, 8'h0F);
    chk("async_seg_b", seg_b, 8'hFF); chk("async_dig_b", {4'h0, dig_b}, 8'h00);
    repeat (2) @(negedge clk);
    brightness = 4'hF;
    reset_n = 1'b1;
    wait_out(3); chk("post_rst_seg", seg_a, 8'h3F); chk("post_rst_dig", {4'h0, dig_a}, 8'h0E);
    wait_out(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Parametrised time-multiplexed 7-segment display driver. It scans DIGITS hex digits and supports per-digit decimal point, per-digit blanking, leading-zero suppression, PWM brightness, anti-ghost guard time and tear-free frame-synchronous updates. It sits between datapath status registers (counters, received bytes, parity flags) and the board's common-anode/cathode display pins.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8); digit 0 is the least significant (rightmost).
SCAN_DIV, 10000, clk cycles per digit slot (>= 8).
PWM_BITS, 4, brightness resolution.
GUARD, 2, cycles at the start of each slot with all digits off (anti-ghosting); must be < SCAN_DIV.
SEG_ACT_LOW, 0, 1 inverts all seg outputs.
DIG_ACT_LOW, 1, 1 means a digit is enabled by driving 0.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
data  in  4*DIGITS  hex nibbles; nibble i = data[4i+3:4i]
dp_en  in  DIGITS  decimal point per digit
blank  in  DIGITS  force digit i dark
lz_suppress  in  1  enable leading-zero blanking
brightness  in  PWM_BITS  0 = dimmest lit level, all-ones = full
load  in  1  one-cycle strobe: capture data/dp_en/blank/lz_suppress into staging
seg  out  8  {dp,g,f,e,d,c,b,a}, registered
dig  out  DIGITS  one-hot digit enable, registered
frame_done  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset (reset_n=0, asynchronous): prescaler=0, idx=0, staging/active regs=0, pending=0, frame_done=0, seg=all segments off, dig=all digits inactive (honouring the polarity parameters). All registers change on the clk rising edge only after release.
- Prescaler counts 0..SCAN_DIV-1 and then wraps; slot end = (prescaler==SCAN_DIV-1). At slot end idx advances; idx wraps DIGITS-1 -> 0. frame_done pulses on the cycle after the slot end of idx=DIGITS-1.
- load=1: staging <= inputs, pending <= 1. At frame boundary (slot end with idx=DIGITS-1): if pending, active <= staging and pending <= 0. If load coincides with the frame boundary, the newly loaded values go to staging only and are copied at the next boundary. Repeated loads before a boundary: the last one wins.
- brightness is not staged; it is sampled live.
- on_ticks = ((brightness+1)*SCAN_DIV) >> PWM_BITS, computed at width clog2(SCAN_DIV)+PWM_BITS+1 with no truncation before the shift. Digit lit iff GUARD <= prescaler < max(on_ticks, GUARD+1). The lit window is at least one cycle. Full brightness lights the slot from GUARD to the slot end.
- Digit i is dark if: active blank[i]=1; OR lz_suppress=1, i>0, and nibbles i..DIGITS-1 are all zero. Digit 0 is never suppressed. Dark means dig is inactive for that slot; seg is driven off.
- Decode: standard hex 0-F (0=0x3F, 1=0x06, ..., 8=0x7F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71). Bit 7 = active dp_en[idx]. Apply SEG_ACT_LOW inversion last.
- Latency: seg/dig are registered one cycle after the prescaler/idx state that selects them. Digit transitions always pass through at least GUARD cycles with dig fully inactive.
- reset_n asserted mid-frame: outputs go off immediately. After release the scan restarts at idx=0 with active=0, so the display shows "0" on digit 0 if unsuppressed.

Test Plan:
- Basic scan (DIGITS=4, SCAN_DIV=8, GUARD=2, brightness=F): load data=0x12AF, lz_suppress=0. After one frame boundary, dig walks 1110,1101,1011,0111. seg equals 0x71, 0x77, 0x5B, 0x06 during the lit cycles 2..7 of each slot (registered, shifted by 1). frame_done pulses once per 32 cycles.
- Leading zeros: load data=0x0050, lz_suppress=1 -> digits 3 and 2 are dark, digit 1 = 0x6D, digit 0 = 0x3F. Repeat with data=0x0000 -> only digit 0 is lit, showing 0x3F.
- Tear-free update: load 0x1111, then load 0x2222 mid-frame -> the current frame completes showing 1s. The next frame shows 2s. Load asserted on the boundary cycle is deferred by one frame.
- Brightness (SCAN_DIV=16, PWM_BITS=4): brightness=0 -> lit exactly 1 cycle/slot (at prescaler 2). brightness=7 -> lit for prescaler 2..7. brightness=F -> lit for prescaler 2..15.
- Blank/dp: blank=0100, dp_en=0001, data=0x8888 -> digit 2 is dark, digit 0 seg=0xFF, others 0x7F. With SEG_ACT_LOW=1, values are inverted (0x00, 0x80).
- Async reset: assert reset_n low mid-slot, not clock-aligned -> dig=1111 and seg=0x00 without waiting for a clk edge. After release, the first lit slot is digit 0 showing 0x3F.
